// File: rtl/led_shift_driver_pkg.sv
// led_shift_driver_pkg
// Shared front-panel definitions: serial-driver state encoding, the default
// frame geometry (3 rows of 24 bits) and the length of the chain-clear pulse.
// No ports; imported with "import led_shift_driver_pkg::*;".

package led_shift_driver_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        SHIFT = 2'd2,
        LOAD  = 2'd3
    } shift_state_t;

    localparam int PANEL_ROWS       = 3;
    localparam int PANEL_ROW_BITS   = 24;
    localparam int PANEL_FRAME_BITS = PANEL_ROWS * PANEL_ROW_BITS;

    // Cycles that sclr_n is held low at the start of a frame when clearing is built in.
    localparam int CLEAR_CYCLES = 2;

    // Cycles spent outside IDLE for one frame: optional clear, WIDTH full sclk
    // periods, then the sload strobe.
    function automatic int frame_cycles(input int width, input int clk_div, input bit clear_en);
        return (clear_en ? CLEAR_CYCLES : 0) + 2 * clk_div * width + clk_div;
    endfunction

endpackage

// File: rtl/led_shift_driver_if.sv
// led_shift_driver_if
// Bundles the formatter-facing frame input and the serial chain outputs.
//   display_bits   : packed frame, bit WIDTH-1 is shifted first
//   bits_valid     : capture display_bits into the pending register
//   timer_overflow : one-cycle pulse on every refresh-timer wrap
//   frame_done     : one-cycle pulse after the sload strobe ends
//   sclk/sdata     : shift clock / serial data to the external chain
//   sload          : active-high output-latch strobe
//   sclr_n         : active-low clear to the external chain
// Modports: master = formatter side, slave = led_shift_driver.

interface led_shift_driver_if
    import led_shift_driver_pkg::*;
#(
    parameter int WIDTH = PANEL_FRAME_BITS
);

    logic [WIDTH-1:0] display_bits;
    logic             bits_valid;
    logic             timer_overflow;
    logic             frame_done;
    logic             sclk;
    logic             sdata;
    logic             sload;
    logic             sclr_n;

    modport master (
        output display_bits,
        output bits_valid,
        input  timer_overflow,
        input  frame_done,
        input  sclk,
        input  sdata,
        input  sload,
        input  sclr_n
    );

    modport slave (
        input  display_bits,
        input  bits_valid,
        output timer_overflow,
        output frame_done,
        output sclk,
        output sdata,
        output sload,
        output sclr_n
    );

endinterface

// File: rtl/led_shift_driver_refresh_timer.sv
// refresh_timer
// Free-running counter 0..REFRESH_CYCLES-1 with a registered one-cycle pulse
// on every wrap. Shared with the display formatter for multiplex stepping.
// Ports:
//   clk      : system clock
//   rst_n    : asynchronous active-low reset
//   overflow : high for the single cycle following each wrap

module refresh_timer #(
    parameter int REFRESH_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    output logic overflow
);

    localparam int CW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(REFRESH_CYCLES - 1);

    logic [CW-1:0] count;

    // Count up and wrap; the wrap and the pulse happen on the same edge so the
    // pulse always lines up with count returning to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            overflow <= 1'b0;
        end else if (count == LAST) begin
            count    <= '0;
            overflow <= 1'b1;
        end else begin
            count    <= count + 1'b1;
            overflow <= 1'b0;
        end
    end

endmodule

// File: rtl/led_shift_driver.sv
// led_shift_driver
// Serial back end of the front-panel display. Keeps a pending snapshot of the
// formatter's packed frame and, on every refresh-timer overflow, shifts it
// MSB-first into the external shift-register chain, then strobes sload.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : led_shift_driver_if.slave (frame input, timer/frame pulses,
//           sclk/sdata/sload/sclr_n to the chain)
// Build option: define LED_SHIFT_CLEAR_EN to start every frame with a
// two-cycle sclr_n pulse; without it frames go straight from IDLE to SHIFT.
// All outputs are registered.

module led_shift_driver
    import led_shift_driver_pkg::*;
#(
    parameter int WIDTH          = PANEL_FRAME_BITS,
    parameter int CLK_DIV        = 4,
    parameter int REFRESH_CYCLES = 50000
) (
    input  logic              clk,
    input  logic              rst_n,
    led_shift_driver_if.slave bus
);

`ifdef LED_SHIFT_CLEAR_EN
    localparam bit CLEAR_EN = 1'b1;
`else
    localparam bit CLEAR_EN = 1'b0;
`endif

    localparam int FRAME_LEN = frame_cycles(WIDTH, CLK_DIV, CLEAR_EN);

    // One counter times both the sclk half-periods and the clear pulse.
    localparam int CNT_W = $clog2(CLK_DIV + CLEAR_CYCLES);
    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [CNT_W-1:0] CD_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
`ifdef LED_SHIFT_CLEAR_EN
    localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_CYCLES - 1);
`endif

    if (CLK_DIV < 1) begin : g_bad_clk_div
        $error("led_shift_driver: CLK_DIV must be at least 1");
    end
    if (REFRESH_CYCLES <= FRAME_LEN) begin : g_bad_refresh
        $error("led_shift_driver: REFRESH_CYCLES must exceed the frame length");
    end

    shift_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] pending_q;
    logic             sclk_q, sclk_d;
    logic             sdata_q, sdata_d;
    logic             sload_q, sload_d;
    logic             sclr_n_q, sclr_n_d;
    logic             frame_done_q, frame_done_d;
    logic             timer_ovf;

    refresh_timer #(
        .REFRESH_CYCLES (REFRESH_CYCLES)
    ) u_refresh_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .overflow (timer_ovf)
    );

    // Pending snapshot: any bits_valid overwrites it, even mid-frame, because
    // the frame in flight works from its own copy in shift_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else if (bus.bits_valid) begin
            pending_q <= bus.display_bits;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            sclk_q       <= 1'b0;
            sdata_q      <= 1'b0;
            sload_q      <= 1'b0;
            sclr_n_q     <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            sclk_q       <= sclk_d;
            sdata_q      <= sdata_d;
            sload_q      <= sload_d;
            sclr_n_q     <= sclr_n_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Next state and next output values. sdata only changes when a new bit
    // is presented, so it keeps the last shifted bit through LOAD and IDLE.
    // An overflow seen outside IDLE is simply not looked at.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        sclk_d       = sclk_q;
        sdata_d      = sdata_q;
        sload_d      = sload_q;
        sclr_n_d     = 1'b1;
        frame_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (timer_ovf) begin
                    shift_d = pending_q;
                    cnt_d   = '0;
                    bit_d   = '0;
                    sclk_d  = 1'b0;
`ifdef LED_SHIFT_CLEAR_EN
                    state_d  = CLEAR;
                    sclr_n_d = 1'b0;
`else
                    state_d = SHIFT;
                    sdata_d = pending_q[WIDTH-1];
`endif
                end
            end

`ifdef LED_SHIFT_CLEAR_EN
            CLEAR: begin
                if (cnt_q == CLEAR_LAST) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    sdata_d = shift_q[WIDTH-1];
                end else begin
                    sclr_n_d = 1'b0;
                    cnt_d    = cnt_q + 1'b1;
                end
            end
`endif

            SHIFT: begin
                if (cnt_q == CD_LAST) begin
                    cnt_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        // Falling edge: advance to the next bit, or finish.
                        sclk_d  = 1'b0;
                        shift_d = shift_q << 1;
                        if (bit_q == BIT_LAST) begin
                            state_d = LOAD;
                            sload_d = 1'b1;
                        end else begin
                            bit_d   = bit_q + 1'b1;
                            sdata_d = shift_d[WIDTH-1];
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            LOAD: begin
                if (cnt_q == CD_LAST) begin
                    cnt_d        = '0;
                    sload_d      = 1'b0;
                    frame_done_d = 1'b1;
                    state_d      = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.timer_overflow = timer_ovf;
    assign bus.frame_done     = frame_done_q;
    assign bus.sclk           = sclk_q;
    assign bus.sdata          = sdata_q;
    assign bus.sload          = sload_q;
    assign bus.sclr_n         = sclr_n_q;

endmodule

// File: tb/tb_led_shift_driver.sv
// tb_led_shift_driver
// Directed bench for led_shift_driver with WIDTH=8, CLK_DIV=2,
// REFRESH_CYCLES=64. Expected frame timing follows LED_SHIFT_CLEAR_EN.
// Outputs are sampled on the falling edge of clk.

module tb_led_shift_driver;

    localparam int W  = 8;
    localparam int CD = 2;
    localparam int RC = 64;
`ifdef LED_SHIFT_CLEAR_EN
    localparam int CLR = 2;
`else
    localparam int CLR = 0;
`endif
    // Cycle offsets counted from the sample where timer_overflow is seen high.
    localparam int FIRST_RISE  = 1 + CLR + CD;
    localparam int DONE_T      = 1 + CLR + 2 * CD * W + CD;
    localparam int INJ_T       = FIRST_RISE + 2 * 2 * CD;
    localparam int FRAME_BOUND = 100;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;
    int   lastOvf;
    int   relCyc;

    led_shift_driver_if #(.WIDTH(W)) bus ();

    led_shift_driver #(
        .WIDTH          (W),
        .CLK_DIV        (CD),
        .REFRESH_CYCLES (RC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Free cycle counter, settled by the time of each negedge sample.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // One-cycle bits_valid pulse carrying a new frame.
    task automatic applyStimulus(input logic [W-1:0] value);
        @(negedge clk);
        bus.display_bits = value;
        bus.bits_valid   = 1'b1;
        @(negedge clk);
        bus.bits_valid   = 1'b0;
    endtask

    // Wait (bounded) for the next overflow pulse; checks it arrives, its
    // distance from refCyc, and that the chain stayed quiet meanwhile.
    task automatic waitOverflow(input string tag, input int refCyc, input int expGap);
        bit seen;
        bit active;
        seen   = 1'b0;
        active = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge clk);
            if (bus.sclk || bus.sload) active = 1'b1;
            if (bus.timer_overflow) seen = 1'b1;
        end
        checkOutput({tag, "_seen"}, int'(seen), 1);
        checkOutput({tag, "_period"}, cyc - refCyc, expGap);
        checkOutput({tag, "_quiet"}, int'(active), 0);
        lastOvf = cyc;
    endtask

    // Called at the sample where the overflow is high. Collects sdata at each
    // sclk rise and measures the frame's timing; optionally injects a new
    // bits_valid at offset injT (0 = none).
    task automatic captureFrame(input string tag, input logic [W-1:0] expBits,
                                input int injT, input logic [W-1:0] injVal);
        logic [W-1:0] got;
        int  rises, firstRise, clrLow, loadHigh, doneT;
        logic prevSclk;
        bit  done;
        got = '0; rises = 0; firstRise = 0; clrLow = 0; loadHigh = 0; doneT = 0;
        prevSclk = 1'b0; done = 1'b0;
        for (int t = 1; t <= FRAME_BOUND && !done; t++) begin
            @(negedge clk);
            if (injT > 0 && t == injT + 1) bus.bits_valid = 1'b0;
            if (injT > 0 && t == injT) begin
                bus.display_bits = injVal;
                bus.bits_valid   = 1'b1;
            end
            if (t == 1) checkOutput({tag, "_ovf_pulse"}, int'(bus.timer_overflow), 0);
            if (bus.sclk && !prevSclk) begin
                if (rises == 0) firstRise = t;
                got = {got[W-2:0], bus.sdata};
                rises++;
            end
            prevSclk = bus.sclk;
            if (!bus.sclr_n) clrLow++;
            if (bus.sload) loadHigh++;
            if (bus.frame_done) begin
                doneT = t;
                done  = 1'b1;
                checkOutput({tag, "_sdata_hold"}, int'(bus.sdata), int'(expBits[0]));
            end
        end
        checkOutput({tag, "_bits"}, int'(got), int'(expBits));
        checkOutput({tag, "_rises"}, rises, W);
        checkOutput({tag, "_first_rise"}, firstRise, FIRST_RISE);
        checkOutput({tag, "_clr_low"}, clrLow, CLR);
        checkOutput({tag, "_load_len"}, loadHigh, CD);
        checkOutput({tag, "_done_t"}, doneT, DONE_T);
        @(negedge clk);
        checkOutput({tag, "_done_pulse"}, int'(bus.frame_done), 0);
        checkOutput({tag, "_idle_sclr_n"}, int'(bus.sclr_n), 1);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_sclk"}, int'(bus.sclk), 0);
        checkOutput({tag, "_sdata"}, int'(bus.sdata), 0);
        checkOutput({tag, "_sload"}, int'(bus.sload), 0);
        checkOutput({tag, "_sclr_n"}, int'(bus.sclr_n), 0);
        checkOutput({tag, "_ovf"}, int'(bus.timer_overflow), 0);
        checkOutput({tag, "_done"}, int'(bus.frame_done), 0);
    endtask

    initial begin
        cyc = 0; checks = 0; errors = 0; lastOvf = 0; relCyc = 0;
        rst_n            = 1'b1;
        bus.display_bits = '0;
        bus.bits_valid   = 1'b0;
        $display("[TB] led_shift_driver bench, clear pulse cycles = %0d", CLR);
        #2 rst_n = 1'b0;

        // Reset state, then release and time the first overflow.
        repeat (3) @(negedge clk);
        checkResetOutputs("reset");
        rst_n  = 1'b1;
        relCyc = cyc;
        @(negedge clk);
        checkOutput("release_sclr_n", int'(bus.sclr_n), 1);
        checkOutput("release_ovf", int'(bus.timer_overflow), 0);
        waitOverflow("ovf1", relCyc, RC);

        // Nothing captured yet: eight zeros, sload still strobed.
        captureFrame("f1_zero", 8'h00, 0, 8'h00);

        // A5 frame with 3C arriving during the third bit.
        applyStimulus(8'hA5);
        waitOverflow("ovf2", lastOvf, RC);
        captureFrame("f2_a5", 8'hA5, INJ_T, 8'h3C);
        waitOverflow("ovf3", lastOvf, RC);
        captureFrame("f3_3c", 8'h3C, 0, 8'h00);

        // Reset in the middle of the second bit's high phase.
        waitOverflow("ovf4", lastOvf, RC);
        repeat (FIRST_RISE + 2 * CD) @(negedge clk);
        checkOutput("pre_reset_sclk", int'(bus.sclk), 1);
        rst_n = 1'b0;
        #1;
        checkResetOutputs("midreset");
        @(negedge clk);
        rst_n  = 1'b1;
        relCyc = cyc;
        waitOverflow("ovf5", relCyc, RC);
        captureFrame("f5_after_reset", 8'h00, 0, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/led_shift_driver.md
# led_shift_driver

Serial back end of the front-panel display path. Holds a snapshot of the packed LED/digit bit vector produced by the display formatter. On every refresh-timer overflow, shifts the snapshot MSB-first into the external daisy-chained shift-register/driver chips over `sclk`/`sdata`, then strobes `sload`. Exports the timer overflow so the formatter can advance its digit/LED multiplex state.

## Interface
Parameters:
- `WIDTH`, 72, number of bits per frame (3 rows × 24).
- `CLK_DIV`, 4, `clk` cycles per `sclk` half-period; ≥1.
- `REFRESH_CYCLES`, 50000, `clk` cycles between frame starts; must exceed the frame length (elaboration-time check).

Ports:
- `clk`, in, 1, single system clock. One clock; reset is asynchronous and active-low.
- `rst_n`, in, 1, asynchronous active-low reset.
- `display_bits`, in, WIDTH, packed frame; bit WIDTH-1 shifts first.
- `bits_valid`, in, 1, capture `display_bits` into the pending register this cycle.
- `timer_overflow`, out, 1, one-cycle pulse on each refresh-timer wrap.
- `frame_done`, out, 1, one-cycle pulse in the cycle after `sload` deasserts.
- `sclk`, out, 1, shift clock; external chips sample on rising edge.
- `sdata`, out, 1, serial data.
- `sload`, out, 1, active-high output-latch strobe.
- `sclr_n`, out, 1, active-low clear to the external chain.

## Operation
- All outputs are registered. Reset values: `sclk`=0, `sdata`=0, `sload`=0, `sclr_n`=0, `timer_overflow`=0, `frame_done`=0, pending=0, state=IDLE, timer=0.
- Pending register: loads `display_bits` on any cycle with `bits_valid`=1, in any state. It is never cleared except by reset.
- Refresh timer: counts 0..REFRESH_CYCLES-1 and wraps. On wrap, `timer_overflow` is high for 1 cycle. The timer free-runs in all states.
- State machine:
  - IDLE: `sclr_n`=1. On `timer_overflow`, copy pending into the shift register and go to CLEAR (macro on) or SHIFT (macro off).
  - CLEAR: `sclr_n`=0 for 2 cycles, then 1, then go to SHIFT.
  - SHIFT: for each of WIDTH bits:
    - drive `sdata`=shift[MSB] with `sclk`=0 for CLK_DIV cycles;
    - then `sclk`=1 for CLK_DIV cycles;
    - on the falling edge, shift left by one.
    - After bit WIDTH-1, hold `sclk`=0 and go to LOAD.
  - LOAD: `sload`=1 for CLK_DIV cycles, then 0. Assert `frame_done` for the next cycle and return to IDLE.
- A `bits_valid` during a frame does not disturb the frame in flight; the new value appears in the next frame.
- An overflow outside IDLE cannot occur when REFRESH_CYCLES exceeds the frame length. If it does, it is ignored and no frame restarts.
- `sdata` holds the last shifted bit in IDLE/LOAD. It returns to 0 only on reset.

## Timing
- Overflow to first `sclk` rise: 1 cycle, plus 2 (CLEAR, macro on), plus CLK_DIV.
- Frame length: [2] + 2·CLK_DIV·WIDTH + CLK_DIV cycles. Default: 2 + 576 + 4 = 582.
- `sdata` is stable for CLK_DIV cycles before and CLK_DIV cycles after each `sclk` rise.
- `bits_valid` capture latency: 1 cycle to pending. It is eligible for any frame whose start overflow occurs at least 1 cycle later.
- `rst_n` assertion mid-frame forces all outputs to reset values immediately. After release, the first frame starts at the next timer wrap, REFRESH_CYCLES cycles later.

## Configuration
- `LED_SHIFT_CLEAR_EN` defined: every frame begins with the 2-cycle CLEAR pulse on `sclr_n`.
- Not defined: CLEAR state absent; `sclr_n` is low only during reset and goes high on the first clock after release; frames go IDLE→SHIFT directly.

## Structure
- The shared panel package holds the state enum (IDLE, CLEAR, SHIFT, LOAD), the default WIDTH = 3×24 row constants, and the CLEAR length constant 2.
- Sub-module `refresh_timer` (counter + wrap pulse, parameter REFRESH_CYCLES). It is reusable by the formatter.

## Test plan
Bench defaults: WIDTH=8, CLK_DIV=2, REFRESH_CYCLES=64, macro on.
- Reset: hold `rst_n`=0 → `sclk`=`sdata`=`sload`=0, `sclr_n`=0. Release → `sclr_n`=1 next cycle; `timer_overflow` first pulses 64 cycles later.
- `display_bits`=8'hA5 with `bits_valid` pulse → sampled `sdata` at `sclk` rises = 1,0,1,0,0,1,0,1. Then `sload` high 2 cycles, `frame_done` 1 cycle; frame = 2+32+2 cycles.
- `bits_valid` with 8'h3C during the third bit of an A5 frame → current frame completes as A5; next frame shifts 0,0,1,1,1,1,0,0.
- No `bits_valid` since reset → each frame shifts eight zeros and still strobes `sload`.
- `rst_n` pulsed low mid-SHIFT → outputs return to reset values the same cycle. The next `sclk` activity begins only after the next overflow.
- Macro undefined → `sclr_n` stays 1 through all frames; first `sclk` rise is 1+CLK_DIV cycles after overflow.
